// File: rtl/bip_exec_ctrl.sv
// Execution sequencer for the BIP core: gates PC advance from host RUN/STEP/HALT/RESET_CPU
// commands, freezes on the HLT opcode and reports executed-cycle count and halt PC.
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_IDLE   | core paused, waiting for a host command
// S_RUN    | free-running, PC advances every cycle until HLT or HALT cmd
// S_STEP   | single-cycle advance, then back to S_IDLE
// S_HALTED | stopped on HLT opcode; only RESET_CPU leaves
// S_CPURST | core reset held low for RST_CYCLES cycles
module bip_exec_ctrl #(
    parameter int                  OPCODE_W    = 5,
    parameter logic [OPCODE_W-1:0] HALT_OPCODE = '0,
    parameter int                  PC_W        = 11,
    parameter int                  CNT_W       = 16,
    parameter int                  RST_CYCLES  = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cmd_valid,
    input  logic [1:0]          cmd,
    output logic                cmd_ready,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic [PC_W-1:0]     pc,
    output logic                pc_en,
    output logic                cpu_rst_n,
    output logic                halted,
    output logic                done,
    output logic [CNT_W-1:0]    cycle_count,
    output logic [PC_W-1:0]     halt_pc
);

    localparam int              RC_W    = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [RC_W-1:0] RC_LOAD = RC_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    localparam logic [1:0] CMD_RUN   = 2'b00;
    localparam logic [1:0] CMD_STEP  = 2'b01;
    localparam logic [1:0] CMD_HALT  = 2'b10;
    localparam logic [1:0] CMD_RESET = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_STEP,
        S_HALTED,
        S_CPURST
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [RC_W-1:0] rst_cnt;
    logic            executing;
    logic            halt_op;
    logic            halt_det;
    logic            cmd_fire;
    logic            cpurst_entry;

    assign executing    = (state == S_RUN) || (state == S_STEP);
    assign halt_op      = (opcode == HALT_OPCODE);
    assign halt_det     = executing && halt_op;
    assign cmd_ready    = (state == S_IDLE) || (state == S_RUN) || (state == S_HALTED);
    assign cmd_fire     = cmd_valid && cmd_ready;
    assign pc_en        = executing && !halt_op;
    assign cpu_rst_n    = (state != S_CPURST);
    assign halted       = (state == S_HALTED);
    assign cpurst_entry = (state_nxt == S_CPURST) && (state != S_CPURST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (cmd_fire) begin
                    case (cmd)
                        CMD_RUN:   state_nxt = S_RUN;
                        CMD_STEP:  state_nxt = S_STEP;
                        CMD_RESET: state_nxt = S_CPURST;
                        default:   state_nxt = S_IDLE;
                    endcase
                end
            end
            S_RUN: begin
                // HLT opcode outranks any command arriving in the same cycle
                if (halt_op) begin
                    state_nxt = S_HALTED;
                end else if (cmd_fire && cmd == CMD_HALT) begin
                    state_nxt = S_IDLE;
                end else if (cmd_fire && cmd == CMD_RESET) begin
                    state_nxt = S_CPURST;
                end
            end
            S_STEP: begin
                state_nxt = halt_op ? S_HALTED : S_IDLE;
            end
            S_HALTED: begin
                if (cmd_fire && cmd == CMD_RESET) begin
                    state_nxt = S_CPURST;
                end
            end
            S_CPURST: begin
                if (rst_cnt == '0) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rst_cnt <= '0;
        end else if (cpurst_entry) begin
            rst_cnt <= RC_LOAD;
        end else if (state == S_CPURST && rst_cnt != '0) begin
            rst_cnt <= rst_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_count <= '0;
            halt_pc     <= '0;
            done        <= 1'b0;
        end else begin
            done <= halt_det;
            if (cpurst_entry) begin
                cycle_count <= '0;
                halt_pc     <= '0;
            end else begin
                if (pc_en && cycle_count != CNT_MAX) begin
                    cycle_count <= cycle_count + 1'b1;
                end
                if (halt_det) begin
                    halt_pc <= pc;
                end
            end
        end
    end

endmodule

// File: tb/tb_bip_exec_ctrl.sv
// Scoreboard bench for bip_exec_ctrl (4-bit cycle counter build so saturation is reachable).
module tb_bip_exec_ctrl;

    localparam int CNT_W = 4;
    localparam int PC_W  = 11;

    logic             clk = 1'b0;
    logic             rst;
    logic             cmd_valid;
    logic [1:0]       cmd;
    logic             cmd_ready;
    logic [4:0]       opcode;
    logic [PC_W-1:0]  pc;
    logic             pc_en;
    logic             cpu_rst_n;
    logic             halted;
    logic             done;
    logic [CNT_W-1:0] cycle_count;
    logic [PC_W-1:0]  halt_pc;

    bip_exec_ctrl #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd(cmd), .cmd_ready(cmd_ready),
        .opcode(opcode), .pc(pc), .pc_en(pc_en), .cpu_rst_n(cpu_rst_n), .halted(halted),
        .done(done), .cycle_count(cycle_count), .halt_pc(halt_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        string           name;
        logic [19:0]     vec;   // {cmd_ready, pc_en, cpu_rst_n, halted, done, cycle_count, halt_pc}
        int              total;
    } snap_t;

    typedef struct {
        logic [PC_W-1:0]  hpc;
        logic [CNT_W-1:0] cnt;
    } done_t;

    snap_t snap_q[$];
    done_t done_q[$];
    int    compared   = 0;
    int    mismatched = 0;
    int    pc_en_total = 0;

    // Monitor: pc_en pulses are tallied first, then done pulses and snapshots are scored.
    always @(negedge clk) begin
        logic [19:0] act;
        if (pc_en) pc_en_total++;
        if (done) begin
            compared++;
            if (done_q.size() == 0) begin
                mismatched++;
                $display("FAIL done_unexpected: got done=1 hpc=%0d cnt=%0d, required no done pulse",
                         halt_pc, cycle_count);
            end else begin
                done_t d;
                d = done_q.pop_front();
                if (halt_pc !== d.hpc || cycle_count !== d.cnt) begin
                    mismatched++;
                    $display("FAIL done_payload: got hpc=%0d cnt=%0d, required hpc=%0d cnt=%0d",
                             halt_pc, cycle_count, d.hpc, d.cnt);
                end
            end
        end
        while (snap_q.size() > 0) begin
            snap_t s;
            s = snap_q.pop_front();
            act = {cmd_ready, pc_en, cpu_rst_n, halted, done, cycle_count, halt_pc};
            compared++;
            if (act !== s.vec || pc_en_total != s.total) begin
                mismatched++;
                $display("FAIL %s: got rdy/pcen/rstn/hlt/done=%b cnt=%0d hpc=%0d pcen_total=%0d, required %b cnt=%0d hpc=%0d pcen_total=%0d",
                         s.name, act[19:15], act[14:11], act[10:0], pc_en_total,
                         s.vec[19:15], s.vec[14:11], s.vec[10:0], s.total);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic snap(input string name, input logic rdy, input logic pe, input logic rn,
                        input logic h, input logic d, input int cnt, input int hpc, input int total);
        snap_t s;
        s.name  = name;
        s.vec   = {rdy, pe, rn, h, d, 4'(cnt), 11'(hpc)};
        s.total = total;
        snap_q.push_back(s);
    endtask

    task automatic exp_done(input int hpc, input int cnt);
        done_t d;
        d.hpc = 11'(hpc);
        d.cnt = 4'(cnt);
        done_q.push_back(d);
    endtask

    task automatic issue(input logic [1:0] c);
        cmd_valid = 1'b1;
        cmd       = c;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, required $finish before 100us");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd = 2'b00; opcode = 5'd1; pc = '0;

        // reset
        tick(); tick();
        snap("reset", 1, 0, 1, 0, 0, 0, 0, 0);
        rst = 1'b0;

        // RUN for ten instructions, HLT at pc=10
        issue(2'b00);
        tick();
        cmd_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            pc = PC_W'(i);
            tick();
        end
        pc = 11'd10; opcode = 5'd0;
        snap("run_at_hlt", 1, 0, 1, 0, 0, 10, 0, 10);
        exp_done(10, 10);
        tick();
        snap("halt_entry", 1, 0, 1, 1, 1, 10, 10, 10);
        opcode = 5'd1;
        tick();
        snap("halt_hold", 1, 0, 1, 1, 0, 10, 10, 10);
        issue(2'b00);
        tick();
        cmd_valid = 1'b0;
        snap("halt_ignores_run", 1, 0, 1, 1, 0, 10, 10, 10);

        // RESET_CPU from HALTED; a RUN offered while not ready must be dropped
        issue(2'b11);
        tick();
        issue(2'b00);
        snap("cpurst_1", 0, 0, 0, 0, 0, 0, 0, 10);
        tick();
        cmd_valid = 1'b0;
        snap("cpurst_2", 0, 0, 0, 0, 0, 0, 0, 10);
        tick();
        snap("cpurst_exit", 1, 0, 1, 0, 0, 0, 0, 10);

        // three back-to-back STEPs
        issue(2'b01);
        for (int k = 0; k < 3; k++) begin
            snap("step_idle", 1, 0, 1, 0, 0, k, 0, 10 + k);
            tick();
            snap("step_busy", 0, 1, 1, 0, 0, k, 0, 11 + k);
            tick();
        end
        cmd_valid = 1'b0;
        snap("step_done", 1, 0, 1, 0, 0, 3, 0, 13);

        // HLT opcode and HALT command in the same cycle: opcode wins
        issue(2'b00);
        tick();
        cmd_valid = 1'b0; pc = 11'd5;
        snap("run_again", 1, 1, 1, 0, 0, 3, 0, 14);
        tick();
        opcode = 5'd0; pc = 11'd7; issue(2'b10);
        snap("hlt_vs_halt", 1, 0, 1, 0, 0, 4, 0, 14);
        exp_done(7, 4);
        tick();
        cmd_valid = 1'b0;
        snap("hlt_wins", 1, 0, 1, 1, 1, 4, 7, 14);

        // saturation of the 4-bit counter
        issue(2'b11); opcode = 5'd1;
        tick();
        cmd_valid = 1'b0;
        tick(); tick();
        issue(2'b00);
        tick();
        cmd_valid = 1'b0;
        repeat (20) tick();
        snap("saturate", 1, 1, 1, 0, 0, 15, 0, 35);

        // rst during CPURST returns to IDLE immediately
        issue(2'b11);
        tick();
        cmd_valid = 1'b0;
        snap("sat_cpurst", 0, 0, 0, 0, 0, 0, 0, 35);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        snap("rst_mid_cpurst", 1, 0, 1, 0, 0, 0, 0, 35);

        // HALT command while running returns to IDLE
        issue(2'b00);
        tick();
        issue(2'b10);
        tick();
        cmd_valid = 1'b0;
        snap("run_halt_cmd", 1, 0, 1, 0, 0, 1, 0, 36);
        tick(); tick();

        compared++;
        if (done_q.size() != 0 || snap_q.size() != 0) begin
            mismatched++;
            $display("FAIL drain: got %0d done / %0d snapshots pending, required 0 / 0",
                     done_q.size(), snap_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
